// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state type, default timing constants
// and the parity helper used by both the receive and transmit sides.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 10416;
  localparam int DATA_BITS_DEFAULT    = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  // Data is zero-extended by the caller, so the extra bits do not disturb the XOR.
  function automatic logic parity_mismatch(input logic [63:0] data, input logic parity_bit);
    return (^data) ^ parity_bit;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial-line and received-frame bundle between a UART receiver (slave)
// and whatever drives the line and consumes the frames (master).
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);

  logic                 rx_in;
  logic                 parity_enable;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 parity_err;
  logic                 frame_err;

  modport master (
    output rx_in,
    output parity_enable,
    input  rx_data,
    input  rx_valid,
    input  parity_err,
    input  frame_err
  );

  modport slave (
    input  rx_in,
    input  parity_enable,
    output rx_data,
    output rx_valid,
    output parity_err,
    output frame_err
  );

endinterface

// File: rtl/uart_bit_timer.sv
// Loadable down-counter for bit timing: expires load_value+1 cycles after a
// load strobe, stops at zero and never wraps.
module uart_bit_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expire
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] count_r;
  logic             armed_r;

  // Expiry is a single-cycle event: the armed flag drops once zero is reached.
  assign expire = armed_r & (count_r == ZERO);

  // Counter and armed flag; a load wins over an expiry in the same cycle.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      count_r <= ZERO;
      armed_r <= 1'b0;
    end else if (load) begin
      count_r <= load_value;
      armed_r <= 1'b1;
    end else begin
      if (count_r != ZERO) begin
        count_r <= count_r - ONE;
      end
      if (expire) begin
        armed_r <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: two-flop line synchronizer, mid-bit sampling FSM, optional
// even parity and stop-bit check, one-cycle rx_valid per received frame.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int DATA_BITS    = DATA_BITS_DEFAULT
) (
  input  logic     clk,
  input  logic     reset_n,
  uart_rx_if.slave bus
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic                 sync1_r;
  logic                 rx_s;
  rx_state_t            state_r;
  rx_state_t            state_next_s;

  logic                 timer_load_s;
  logic [TW-1:0]        timer_value_s;
  logic                 timer_expire_s;

  logic                 start_cond_s;
  logic                 arm_s;
  logic                 shift_en_s;
  logic                 par_sample_s;
  logic                 frame_done_s;

  logic [CW-1:0]        bit_cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 par_en_r;
  logic                 par_err_pend_r;
  logic                 wait_high_r;
  logic [DATA_BITS-1:0] rx_data_r;
  logic                 rx_valid_r;
  logic                 parity_err_r;
  logic                 frame_err_r;

  uart_bit_timer #(
    .WIDTH (TW)
  ) u_bit_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (timer_load_s),
    .load_value (timer_value_s),
    .expire     (timer_expire_s)
  );

  // After a frame error the line must be seen high once before a new start is accepted.
  assign start_cond_s = ~wait_high_r & ~rx_s;

  // Two-flop synchronizer for the asynchronous line, idling high.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      sync1_r <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync1_r <= bus.rx_in;
      rx_s    <= sync1_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_cond_s) begin
          state_next_s = START;
        end else begin
          state_next_s = IDLE;
        end
      end
      START: begin
        if (timer_expire_s) begin
          if (rx_s) begin
            state_next_s = IDLE;
          end else begin
            state_next_s = DATA;
          end
        end else begin
          state_next_s = START;
        end
      end
      DATA: begin
        if (timer_expire_s && (bit_cnt_r == LAST_BIT)) begin
          if (par_en_r) begin
            state_next_s = PARITY;
          end else begin
            state_next_s = STOP;
          end
        end else begin
          state_next_s = DATA;
        end
      end
      PARITY: begin
        if (timer_expire_s) begin
          state_next_s = STOP;
        end else begin
          state_next_s = PARITY;
        end
      end
      STOP: begin
        if (timer_expire_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = STOP;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // FSM outputs: timer control and datapath strobes.
  always_comb begin
    arm_s         = 1'b0;
    shift_en_s    = 1'b0;
    par_sample_s  = 1'b0;
    frame_done_s  = 1'b0;
    timer_load_s  = 1'b0;
    timer_value_s = FULL_LOAD;
    case (state_r)
      IDLE: begin
        arm_s         = start_cond_s;
        timer_load_s  = start_cond_s;
        timer_value_s = HALF_LOAD;
      end
      START: begin
        timer_load_s = timer_expire_s & ~rx_s;
      end
      DATA: begin
        shift_en_s   = timer_expire_s;
        timer_load_s = timer_expire_s;
      end
      PARITY: begin
        par_sample_s = timer_expire_s;
        timer_load_s = timer_expire_s;
      end
      STOP: begin
        frame_done_s = timer_expire_s;
      end
      default: begin
        arm_s = 1'b0;
      end
    endcase
  end

  // Receive datapath: shift register, bit count, parity and reported results.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      bit_cnt_r      <= {CW{1'b0}};
      shift_r        <= {DATA_BITS{1'b0}};
      par_en_r       <= 1'b0;
      par_err_pend_r <= 1'b0;
      wait_high_r    <= 1'b0;
      rx_data_r      <= {DATA_BITS{1'b0}};
      rx_valid_r     <= 1'b0;
      parity_err_r   <= 1'b0;
      frame_err_r    <= 1'b0;
    end else begin
      if (arm_s) begin
        par_en_r       <= bus.parity_enable;
        par_err_pend_r <= 1'b0;
        bit_cnt_r      <= {CW{1'b0}};
      end
      if (shift_en_s) begin
        shift_r   <= {rx_s, shift_r[DATA_BITS-1:1]};
        bit_cnt_r <= bit_cnt_r + CNT_ONE;
      end
      if (par_sample_s) begin
        par_err_pend_r <= parity_mismatch(64'(shift_r), rx_s);
      end
      rx_valid_r <= frame_done_s;
      if (frame_done_s) begin
        rx_data_r    <= shift_r;
        parity_err_r <= par_err_pend_r & par_en_r;
        frame_err_r  <= ~rx_s;
      end
      if (frame_done_s && !rx_s) begin
        wait_high_r <= 1'b1;
      end else if (rx_s) begin
        wait_high_r <= 1'b0;
      end
    end
  end

  assign bus.rx_data    = rx_data_r;
  assign bus.rx_valid   = rx_valid_r;
  assign bus.parity_err = parity_err_r;
  assign bus.frame_err  = frame_err_r;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a bit-accurate line driver with fractional
// baud skew, a frame-level reference model and a decoupled output monitor.
module tb_uart_rx;

  localparam int CPB = 16;
  localparam int DB  = 8;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;

  int         compared   = 0;
  int         mismatched = 0;
  exp_t       sb_q[$];
  exp_t       mon_e;
  logic [7:0] last_data = 8'h00;

  always #5 clk = ~clk;

  uart_rx_if #(.DATA_BITS(DB)) bus ();

  uart_rx #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Monitor: every rx_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) begin
      compared++;
      if (sb_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_frame: got data=%h perr=%b ferr=%b, required no rx_valid",
                 bus.rx_data, bus.parity_err, bus.frame_err);
      end else begin
        mon_e = sb_q.pop_front();
        last_data = mon_e.data;
        if ({bus.rx_data, bus.parity_err, bus.frame_err} !== mon_e) begin
          mismatched++;
          $display("FAIL frame: got data=%h perr=%b ferr=%b, required data=%h perr=%b ferr=%b",
                   bus.rx_data, bus.parity_err, bus.frame_err, mon_e.data, mon_e.perr, mon_e.ferr);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.rx_in = 1'b1;
    repeat (n) tick();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Reference model: even parity error and stop-bit error straight from the frame content.
  task automatic expect_frame(input logic [7:0] d, input bit pe, input bit pbit, input bit stop);
    exp_t e;
    e.data = d;
    e.perr = pe ? ((^d) ^ pbit) : 1'b0;
    e.ferr = ~stop;
    sb_q.push_back(e);
  endtask

  // Line driver; per is the bit period in hundredths of a clock so skew accumulates exactly.
  task automatic send_frame(input logic [7:0] d, input bit pe, input bit pbit, input bit stop,
                            input int per, input bit flip_pe);
    bit bits[$];
    int e = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < DB; i++) bits.push_back(d[i]);
    if (pe) bits.push_back(pbit);
    bits.push_back(stop);
    bus.parity_enable = pe;
    for (int i = 0; i < bits.size(); i++) begin
      bus.rx_in = bits[i];
      if (i == 1 && flip_pe) bus.parity_enable = ~pe;
      while (e * 100 < (i + 1) * per) begin
        tick();
        e++;
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    compared++;
    if (sb_q.size() != 0) begin
      mismatched++;
      $display("FAIL %s_timeout: got %0d frames outstanding, required 0", name, sb_q.size());
      sb_q.delete();
    end else begin
      repeat (5) tick();
      check({name, "_hold"}, 32'(bus.rx_data), 32'(last_data));
    end
  endtask

  initial begin
    logic [7:0] d;
    bit pe, bad, stop, flip;

    reset_n = 1'b1;
    bus.rx_in = 1'b1;
    bus.parity_enable = 1'b0;
    repeat (5) tick();
    reset_n = 1'b0;
    tick();
    check("reset_rx_data",    32'(bus.rx_data),    32'h0);
    check("reset_rx_valid",   32'(bus.rx_valid),   32'h0);
    check("reset_parity_err", 32'(bus.parity_err), 32'h0);
    check("reset_frame_err",  32'(bus.frame_err),  32'h0);
    idle(10);

    expect_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1600, 1'b0);
    idle(4);
    wait_drain("a5_nopar");

    expect_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1600, 1'b0);
    idle(4);
    wait_drain("3c_par_ok");

    expect_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1600, 1'b0);
    idle(4);
    wait_drain("3c_par_bad");

    // Break: bad stop bit then the line held low must yield a single frame error.
    expect_frame(8'h81, 1'b0, 1'b0, 1'b0);
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1600, 1'b0);
    bus.rx_in = 1'b0;
    repeat (40) tick();
    bus.rx_in = 1'b1;
    wait_drain("break");
    idle(200);

    bus.rx_in = 1'b0;
    repeat (3) tick();
    idle(CPB / 2 + 3 + 5);
    expect_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1600, 1'b0);
    idle(4);
    wait_drain("after_glitch");

    // Reset in the middle of a frame, after four data bits.
    bus.parity_enable = 1'b0;
    bus.rx_in = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 4; i++) begin
      bus.rx_in = i[0];
      repeat (CPB) tick();
    end
    reset_n = 1'b1;
    bus.rx_in = 1'b1;
    repeat (3) tick();
    reset_n = 1'b0;
    tick();
    check("midreset_rx_data", 32'(bus.rx_data), 32'h0);
    check("midreset_rx_valid", 32'(bus.rx_valid), 32'h0);
    last_data = 8'h00;
    idle(10);
    expect_frame(8'h55, 1'b0, 1'b0, 1'b1);
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1600, 1'b0);
    idle(4);
    wait_drain("after_reset");

    for (int s = 0; s < 2; s++) begin
      expect_frame(8'h00, 1'b0, 1'b0, 1'b1);
      expect_frame(8'hFF, 1'b0, 1'b0, 1'b1);
      expect_frame(8'h55, 1'b0, 1'b0, 1'b1);
      send_frame(8'h00, 1'b0, 1'b0, 1'b1, (s == 0) ? 1648 : 1552, 1'b0);
      send_frame(8'hFF, 1'b0, 1'b0, 1'b1, (s == 0) ? 1648 : 1552, 1'b0);
      send_frame(8'h55, 1'b0, 1'b0, 1'b1, (s == 0) ? 1648 : 1552, 1'b0);
      idle(4);
      wait_drain((s == 0) ? "skew_slow" : "skew_fast");
    end

    for (int k = 0; k < 24; k++) begin
      d    = 8'($urandom);
      pe   = 1'($urandom_range(0, 1));
      bad  = ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 5) != 0);
      flip = 1'($urandom_range(0, 1));
      expect_frame(d, pe, (^d) ^ bad, stop);
      send_frame(d, pe, (^d) ^ bad, stop, 1600, flip);
      idle($urandom_range(4, 20));
    end
    wait_drain("random");

    idle(50);
    check("final_queue_empty", 32'(sb_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
